ise_pixel_feeder: RTL and testbench

//  Upstream stage of the image sorting engine. Fetches 32 images x 16384 24-bit RGB

---
 rtl/ise_pixel_feeder.sv | 156 +++++++++++++++
 tb/tb_ise_pixel_feeder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ise_pixel_feeder.sv
// ise_pixel_feeder
//   Upstream stage of the image sorting engine. It walks the image memory
//   address space one image at a time, {img, pix}, and streams the pixels
//   into the sorter. A small prefetch FIFO hides the one-cycle memory read
//   latency, so the stream runs at one pixel per cycle while busy_in is low.
//   Between images the feeder waits for the sorter's busy pulse to rise and
//   fall before it starts the next image. After the last image it parks in
//   DONE until reset.
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   start        one-cycle start pulse; only honoured in IDLE
//   mem_rd       read strobe to the image memory
//   mem_addr     read address {img, pix}
//   mem_rdata    read data, valid the cycle after mem_rd
//   busy_in      sorter busy; a pixel is accepted when pix_valid && !busy_in
//   pix_valid    FIFO head holds a valid pixel
//   pixel_out    FIFO head pixel {R,G,B}
//   image_index  image number of the head pixel
//   done         all images streamed and the final busy pulse has ended
module ise_pixel_feeder #(
  parameter int NUM_IMG     = 32,
  parameter int PIX_PER_IMG = 16384,
  parameter int DW          = 24,
  parameter int FIFO_DEPTH  = 2,
  localparam int IW = $clog2(NUM_IMG),
  localparam int PW = $clog2(PIX_PER_IMG),
  localparam int AW = IW + PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          busy_in,
  output logic          pix_valid,
  output logic [DW-1:0] pixel_out,
  output logic [IW-1:0] image_index,
  output logic          done
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int CW1  = CW + 1;
  localparam logic [CW:0]   DEPTH_C  = CW1'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PIX = PW'(PIX_PER_IMG - 1);
  localparam logic [IW-1:0] LAST_IMG = IW'(NUM_IMG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [IW-1:0]   r_img;
  logic [PW-1:0]   r_pix;
  logic            r_inflight;
  logic [IW-1:0]   r_inflight_img;
  logic [DW-1:0]   r_fifo_pix [FIFO_DEPTH];
  logic [IW-1:0]   r_fifo_img [FIFO_DEPTH];
  logic [PTRW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic            w_push;
  logic            w_last_issue;
  logic [CW:0]     w_credit;

  assign pix_valid   = (r_count != '0);
  assign pixel_out   = r_fifo_pix[r_rd_ptr];
  assign image_index = r_fifo_img[r_rd_ptr];
  assign mem_addr    = {r_img, r_pix};
  assign done        = (r_state == S_DONE);

  assign w_pop  = pix_valid && !busy_in;
  assign w_push = r_inflight;

  // Occupancy the FIFO will have after this cycle's pop, counting the read
  // already in flight; a new read is only issued if it is guaranteed a slot.
  assign w_credit     = {1'b0, r_count} + CW1'(r_inflight) - CW1'(w_pop);
  assign w_last_issue = mem_rd && (r_pix == LAST_PIX);

  always_comb begin
    w_state_next = r_state;
    mem_rd       = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_FETCH;
      S_FETCH: begin
        mem_rd = (w_credit < DEPTH_C);
        if (w_last_issue) w_state_next = S_DRAIN;
      end
      S_DRAIN:   if (r_count == '0 && !r_inflight) w_state_next = S_WAIT_HI;
      S_WAIT_HI: if (busy_in) w_state_next = S_WAIT_LO;
      S_WAIT_LO: if (!busy_in) w_state_next = (r_img == LAST_IMG) ? S_DONE : S_FETCH;
      S_DONE:    w_state_next = S_DONE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_img          <= '0;
      r_pix          <= '0;
      r_inflight     <= 1'b0;
      r_inflight_img <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= mem_rd;
      if (mem_rd) begin
        r_inflight_img <= r_img;
        r_pix          <= w_last_issue ? '0 : r_pix + PW'(1);
      end
      if (r_state == S_WAIT_LO && !busy_in && r_img != LAST_IMG) begin
        r_img <= r_img + IW'(1);
        r_pix <= '0;
      end
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTRW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTRW'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTRW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTRW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage; entries are cleared so the head reads zero out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_fifo_pix[gi] <= '0;
          r_fifo_img[gi] <= '0;
        end else if (w_push && r_wr_ptr == PTRW'(gi)) begin
          r_fifo_pix[gi] <= mem_rdata;
          r_fifo_img[gi] <= r_inflight_img;
        end
      end
    end
  endgenerate

  // The read credit rule must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(w_push && !w_pop && r_count == CW'(FIFO_DEPTH)))
        else $error("prefetch FIFO overflow");
  end

endmodule

// File: tb/tb_ise_pixel_feeder.sv
module tb_ise_pixel_feeder;

  localparam int NI = 4;
  localparam int NP = 256;
  localparam int DW = 24;
  localparam int FD = 2;
  localparam int IW = $clog2(NI);
  localparam int PW = $clog2(NP);
  localparam int AW = IW + PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy_in = 1'b0;
  logic          pix_valid;
  logic [DW-1:0] pixel_out;
  logic [IW-1:0] image_index;
  logic          done;

  int n_pass = 0;
  int n_total = 0;
  int acc_cnt = 0;
  logic [IW+DW-1:0] exp_q[$];

  ise_pixel_feeder #(
    .NUM_IMG(NI), .PIX_PER_IMG(NP), .DW(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy_in(busy_in), .pix_valid(pix_valid), .pixel_out(pixel_out),
    .image_index(image_index), .done(done)
  );

  always #5 clk = ~clk;

  // Image memory: mem[a] = a, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= DW'(mem_addr);
  end

  // Scoreboard: every accepted pixel must be the next expected one.
  always @(negedge clk) begin
    if (!reset && pix_valid && !busy_in) begin
      logic [IW+DW-1:0] e;
      acc_cnt++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_extra got img=%0d pix=%h required no pixel",
                 image_index, pixel_out);
      end else begin
        e = exp_q.pop_front();
        if ({image_index, pixel_out} !== e)
          $display("FAIL scoreboard got img=%0d pix=%h required img=%0d pix=%h",
                   image_index, pixel_out, e[IW+DW-1:DW], e[DW-1:0]);
        else
          n_pass++;
      end
    end
  end

  function automatic logic [IW+DW-1:0] exp_val(int i, int p);
    logic [AW-1:0] a;
    a = {IW'(i), PW'(p)};
    return {IW'(i), DW'(a)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    busy_in = 1'b0;
    tick;
    tick;
    exp_q.delete();
    acc_cnt = 0;
    reset = 1'b0;
    tick;
  endtask

  task automatic push_img(int i);
    for (int p = 0; p < NP; p++) exp_q.push_back(exp_val(i, p));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Streams n images from the current one with the sorter handshake after
  // each; optionally stalls randomly while an image is streaming.
  task automatic run_images(int first, int n, bit rnd);
    bit ok;
    for (int im = first; im < first + n; im++) begin
      ok = 1'b0;
      for (int k = 0; k < 8 * NP; k++) begin
        tick;
        if (acc_cnt == (im + 1) * NP) begin ok = 1'b1; break; end
        busy_in = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      n_total++;
      if (!ok) $display("FAIL stream_timeout img=%0d got %0d accepts required %0d",
                        im, acc_cnt, (im + 1) * NP);
      else n_pass++;
      busy_in = 1'b1;
      repeat (3) tick;
      busy_in = 1'b0;
      tick;
    end
  endtask

  task automatic wait_queue_empty(string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 8 * NP; k++) begin
      tick;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL %s_drain got %0d pending required 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({mem_rd, mem_addr, pix_valid, pixel_out, image_index, done} !== '0)
      $display("FAIL reset_outputs got rd=%0b addr=%h v=%0b pix=%h img=%0d done=%0b required all 0",
               mem_rd, mem_addr, pix_valid, pixel_out, image_index, done);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_stream;
    logic v0, v1, v2;
    int run;
    bit ok;
    do_reset;
    push_img(0);
    push_img(1);
    pulse_start;
    @(negedge clk); v0 = pix_valid;
    @(negedge clk); v1 = pix_valid;
    @(negedge clk); v2 = pix_valid;
    n_total++;
    if ({v0, v1, v2} !== 3'b001)
      $display("FAIL first_latency got valid seq %b%b%b required 001", v0, v1, v2);
    else n_pass++;
    run = 1;
    for (int k = 0; k < NP + 20; k++) begin
      @(negedge clk);
      if (!pix_valid) break;
      run++;
    end
    n_total++;
    if (run != NP) $display("FAIL no_bubbles got run %0d required %0d", run, NP);
    else n_pass++;
    repeat (4) tick;
    n_total++;
    if (pix_valid !== 1'b0 || done !== 1'b0 || acc_cnt != NP)
      $display("FAIL wait_hi_idle got v=%0b done=%0b acc=%0d required 0 0 %0d",
               pix_valid, done, acc_cnt, NP);
    else n_pass++;
    busy_in = 1'b1;
    repeat (4) tick;
    busy_in = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (pix_valid) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok || pixel_out !== DW'(NP) || image_index !== IW'(1))
      $display("FAIL img1_first got v=%0b pix=%h img=%0d required 1 %h 1",
               pix_valid, pixel_out, image_index, DW'(NP));
    else n_pass++;
    wait_queue_empty("img1");
    n_total++;
    if (acc_cnt != 2 * NP) $display("FAIL img1_count got %0d required %0d", acc_cnt, 2 * NP);
    else n_pass++;
  endtask

  task automatic test_stall;
    bit ok;
    int held;
    do_reset;
    push_img(0);
    pulse_start;
    ok = 1'b0;
    for (int k = 0; k < 2 * NP; k++) begin
      tick;
      if (pix_valid && pixel_out == DW'(100)) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL stall_reach got pix=%h required 000064", pixel_out);
    else n_pass++;
    busy_in = 1'b1;
    held = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (pix_valid && pixel_out == DW'(100) && image_index == IW'(0)) held++;
      tick;
    end
    busy_in = 1'b0;
    n_total++;
    if (held != 3) $display("FAIL stall_hold got %0d held cycles required 3", held);
    else n_pass++;
    tick;
    n_total++;
    if (!pix_valid || pixel_out !== DW'(101))
      $display("FAIL stall_resume got v=%0b pix=%h required 1 000065", pix_valid, pixel_out);
    else n_pass++;
    wait_queue_empty("stall");
    n_total++;
    if (acc_cnt != NP) $display("FAIL stall_count got %0d required %0d", acc_cnt, NP);
    else n_pass++;
  endtask

  task automatic test_toggle;
    do_reset;
    push_img(0);
    pulse_start;
    for (int k = 0; k < 4 * NP; k++) begin
      tick;
      if (acc_cnt >= NP) break;
      busy_in = ~busy_in;
    end
    busy_in = 1'b0;
    repeat (5) tick;
    n_total++;
    if (acc_cnt != NP || exp_q.size() != 0 || pix_valid !== 1'b0)
      $display("FAIL toggle_count got acc=%0d pend=%0d v=%0b required %0d 0 0",
               acc_cnt, exp_q.size(), pix_valid, NP);
    else n_pass++;
  endtask

  task automatic test_full;
    bit ok;
    int sticky;
    do_reset;
    for (int i = 0; i < NI; i++) push_img(i);
    pulse_start;
    run_images(0, NI - 1, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 8 * NP; k++) begin
      tick;
      if (acc_cnt == NI * NP) begin ok = 1'b1; break; end
      busy_in = ($urandom_range(0, 3) == 0);
    end
    n_total++;
    if (!ok || exp_q.size() != 0)
      $display("FAIL full_count got acc=%0d pend=%0d required %0d 0", acc_cnt, exp_q.size(), NI * NP);
    else n_pass++;
    busy_in = 1'b1;
    repeat (3) tick;
    n_total++;
    if (done !== 1'b0) $display("FAIL done_early got %0b required 0", done);
    else n_pass++;
    busy_in = 1'b0;
    tick;
    sticky = 0;
    for (int j = 0; j < 6; j++) begin
      if (done === 1'b1) sticky++;
      busy_in = j[0];
      tick;
    end
    busy_in = 1'b0;
    n_total++;
    if (sticky != 6) $display("FAIL done_sticky got %0d of 6 cycles high required 6", sticky);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int quiet;
    do_reset;
    for (int i = 0; i < NI; i++) push_img(i);
    pulse_start;
    run_images(0, NI - 1, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 4 * NP; k++) begin
      tick;
      if (acc_cnt >= (NI - 1) * NP + NP / 2) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok || image_index !== IW'(NI - 1))
      $display("FAIL midreset_reach got acc=%0d img=%0d required %0d %0d",
               acc_cnt, image_index, (NI - 1) * NP + NP / 2, NI - 1);
    else n_pass++;
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({mem_rd, mem_addr, pix_valid, pixel_out, image_index, done} !== '0)
      $display("FAIL midreset_outputs got rd=%0b addr=%h v=%0b pix=%h img=%0d done=%0b required all 0",
               mem_rd, mem_addr, pix_valid, pixel_out, image_index, done);
    else n_pass++;
    tick;
    exp_q.delete();
    acc_cnt = 0;
    reset = 1'b0;
    quiet = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (!pix_valid && !mem_rd) quiet++;
      tick;
    end
    n_total++;
    if (quiet != 4) $display("FAIL midreset_quiet got %0d quiet cycles required 4", quiet);
    else n_pass++;
    push_img(0);
    pulse_start;
    @(negedge clk);
    n_total++;
    if (mem_rd !== 1'b1 || mem_addr !== '0)
      $display("FAIL restart_addr got rd=%0b addr=%h required 1 000", mem_rd, mem_addr);
    else n_pass++;
    wait_queue_empty("restart");
  endtask

  task automatic test_start_ignored;
    int naddr;
    do_reset;
    push_img(0);
    pulse_start;
    naddr = 0;
    for (int k = 0; k < 4 * NP; k++) begin
      @(negedge clk);
      if (mem_rd) begin
        n_total++;
        if (mem_addr !== AW'(naddr))
          $display("FAIL start_ignored_addr got %h required %h", mem_addr, AW'(naddr));
        else n_pass++;
        naddr++;
      end
      tick;
      start = ((k % 7) == 3);
      if (naddr == NP) break;
    end
    start = 1'b0;
    wait_queue_empty("start_ignored");
    repeat (4) tick;
    n_total++;
    if (naddr != NP || mem_rd !== 1'b0)
      $display("FAIL start_ignored_count got %0d issues rd=%0b required %0d 0", naddr, mem_rd, NP);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_toggle;
    test_full;
    test_reset_mid;
    test_start_ignored;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion (%0d/%0d so far)", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
